// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the parametrised raster timing generator.
// The defaults describe the 396x256 raster at 6.144 MHz.
package video_timing_pkg;

    localparam int DEF_H_TOTAL  = 396;
    localparam int DEF_H_ACT_B  = 25;
    localparam int DEF_H_ACT_E  = 265;
    localparam int DEF_HS_START = 320;
    localparam int DEF_HS_LEN   = 31;
    localparam int DEF_V_TOTAL  = 256;
    localparam int DEF_V_ACT_E  = 224;
    localparam int DEF_VS_START = 226;
    localparam int DEF_VS_LEN   = 5;
    localparam int DEF_HPOS_OFS = 24;
    localparam int DEF_CNT_W    = 9;
    localparam int DEF_RGB_W    = 12;
    localparam int DEF_HOFFS_W  = 5;
    localparam int DEF_VOFFS_W  = 4;

    // True when cnt lies in the len-wide window starting at start, wrapping past total-1.
    function automatic logic in_window(int cnt, int start, int len, int total);
        int diff;
        diff = cnt - start;
        if (diff < 0) diff += total;
        return diff < len;
    endfunction

    // (base + off) mod total for a small signed off, corrected by one period at most.
    function automatic int wrap_add(int base, int off, int total);
        int sum;
        sum = base + off;
        if (sum < 0)
            sum += total;
        else if (sum >= total)
            sum -= total;
        return sum;
    endfunction

endpackage

// File: rtl/video_timing_gen_sync_window.sv
// Registered wrap-around window decoder, used for both hsync and vsync.
module sync_window
    import video_timing_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W:0]   total,
    output logic             flag
);

    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset)
            flag <= 1'b0;
        else if (ce_pix)
            flag <= in_window(int'(cnt), int'(start), int'(len), int'(total));
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator on clk_sys with a pixel clock-enable: counters, blanking,
// sync with frame-latched offsets, game coordinates, blanked RGB and line/frame pulses.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_ACT_B  = DEF_H_ACT_B,
    parameter int H_ACT_E  = DEF_H_ACT_E,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_LEN   = DEF_HS_LEN,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_ACT_E  = DEF_V_ACT_E,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_LEN   = DEF_VS_LEN,
    parameter int HPOS_OFS = DEF_HPOS_OFS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RGB_W    = DEF_RGB_W,
    parameter int HOFFS_W  = DEF_HOFFS_W,
    parameter int VOFFS_W  = DEF_VOFFS_W
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce_pix,
    input  logic signed [HOFFS_W-1:0] hoffs,
    input  logic signed [VOFFS_W-1:0] voffs,
    input  logic [RGB_W-1:0]          rgb_in,
    output logic [CNT_W-1:0]          hpos,
    output logic [CNT_W-1:0]          vpos,
    output logic [RGB_W-1:0]          rgb_out,
    output logic                      hblank,
    output logic                      vblank,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic                      frame_start,
    output logic                      line_start
);

    if (!(H_ACT_B < H_ACT_E && H_ACT_E <= H_TOTAL)) begin : g_chk_hact
        $error("video_timing_gen: need H_ACT_B < H_ACT_E <= H_TOTAL");
    end
    if (!(HS_LEN < H_TOTAL)) begin : g_chk_hslen
        $error("video_timing_gen: need HS_LEN < H_TOTAL");
    end
    if (!(VS_LEN < V_TOTAL)) begin : g_chk_vslen
        $error("video_timing_gen: need VS_LEN < V_TOTAL");
    end
    if (!(H_TOTAL <= 2**CNT_W)) begin : g_chk_htot
        $error("video_timing_gen: H_TOTAL does not fit CNT_W");
    end
    if (!(V_TOTAL <= 2**CNT_W)) begin : g_chk_vtot
        $error("video_timing_gen: V_TOTAL does not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0]          hcnt;
    logic [CNT_W-1:0]          vcnt;
    logic signed [HOFFS_W-1:0] hoffs_l;
    logic signed [VOFFS_W-1:0] voffs_l;
    logic [CNT_W-1:0]          hs_b;
    logic [CNT_W-1:0]          vs_b;
    logic                      h_last;
    logic                      v_last;

    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce_pix) begin
            if (!h_last) begin
                hcnt <= hcnt + CNT_W'(1);
            end else begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
            end
        end
    end

    // Offsets only change on the last pixel of a frame so sync never tears mid-frame.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hoffs_l <= hoffs;
            voffs_l <= voffs;
        end else if (ce_pix && h_last && v_last) begin
            hoffs_l <= hoffs;
            voffs_l <= voffs;
        end
    end

    // rgb_out deliberately uses the already-registered blank flags (one-pixel pipeline).
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hblank  <= 1'b1;
            vblank  <= 1'b1;
            rgb_out <= '0;
        end else if (ce_pix) begin
            hblank  <= (int'(hcnt) < H_ACT_B) || (int'(hcnt) >= H_ACT_E);
            vblank  <= (int'(vcnt) >= V_ACT_E);
            rgb_out <= (hblank || vblank) ? '0 : rgb_in;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= ce_pix && h_last;
            frame_start <= ce_pix && h_last && v_last;
        end
    end

    always_comb begin
        hs_b = CNT_W'(wrap_add(HS_START, int'(hoffs_l), H_TOTAL));
        vs_b = CNT_W'(wrap_add(VS_START, int'(voffs_l), V_TOTAL));
    end

    sync_window #(.CNT_W(CNT_W)) u_hsync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .cnt     (hcnt),
        .start   (hs_b),
        .len     (CNT_W'(HS_LEN)),
        .total   ((CNT_W+1)'(H_TOTAL)),
        .flag    (hsync)
    );

    sync_window #(.CNT_W(CNT_W)) u_vsync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .cnt     (vcnt),
        .start   (vs_b),
        .len     (CNT_W'(VS_LEN)),
        .total   ((CNT_W+1)'(V_TOTAL)),
        .flag    (vsync)
    );

    assign de   = ~(hblank | vblank);
    assign hpos = hcnt - CNT_W'(HPOS_OFS);
    assign vpos = vcnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default raster (A), wrapped-hsync variant (C), and a short-line
// variant (B) so whole frames fit in a small cycle budget.
module tb_video_timing_gen;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic              rst_a, rst_b, ce;
    logic signed [4:0] hoffs;
    logic signed [3:0] voffs;
    logic [11:0]       rgb_in;

    logic [8:0]  a_hpos, a_vpos, b_hpos, b_vpos, c_hpos, c_vpos;
    logic [11:0] a_rgb, b_rgb, c_rgb;
    logic a_hb, a_vb, a_hs, a_vs, a_de, a_fs, a_ls;
    logic b_hb, b_vb, b_hs, b_vs, b_de, b_fs, b_ls;
    logic c_hb, c_vb, c_hs, c_vs, c_de, c_fs, c_ls;

    video_timing_gen u_a (
        .clk_sys(clk_sys), .reset(rst_a), .ce_pix(ce), .hoffs(hoffs), .voffs(voffs),
        .rgb_in(rgb_in), .hpos(a_hpos), .vpos(a_vpos), .rgb_out(a_rgb), .hblank(a_hb),
        .vblank(a_vb), .hsync(a_hs), .vsync(a_vs), .de(a_de), .frame_start(a_fs),
        .line_start(a_ls)
    );

    video_timing_gen #(.HS_START(380)) u_c (
        .clk_sys(clk_sys), .reset(rst_a), .ce_pix(ce), .hoffs(hoffs), .voffs(voffs),
        .rgb_in(rgb_in), .hpos(c_hpos), .vpos(c_vpos), .rgb_out(c_rgb), .hblank(c_hb),
        .vblank(c_vb), .hsync(c_hs), .vsync(c_vs), .de(c_de), .frame_start(c_fs),
        .line_start(c_ls)
    );

    video_timing_gen #(.H_TOTAL(40), .H_ACT_B(4), .H_ACT_E(30), .HS_START(32),
                       .HS_LEN(3), .HPOS_OFS(2)) u_b (
        .clk_sys(clk_sys), .reset(rst_b), .ce_pix(ce), .hoffs(hoffs), .voffs(voffs),
        .rgb_in(rgb_in), .hpos(b_hpos), .vpos(b_vpos), .rgb_out(b_rgb), .hblank(b_hb),
        .vblank(b_vb), .hsync(b_hs), .vsync(b_vs), .de(b_de), .frame_start(b_fs),
        .line_start(b_ls)
    );

    typedef struct {
        int         pos;
        logic       hs;
        logic       hb;
        logic       de;
        logic [11:0] rgb;
        logic [8:0] hpos;
    } line_vec_t;

    typedef struct {
        logic              use_c;
        logic signed [4:0] ho;
        int                idx;
        logic              hs;
    } sync_vec_t;

    typedef struct {
        int   frame;
        int   line;
        logic vb;
        logic vs;
        int   voffs_set;
    } vert_vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int ls_a_hits = 0;
    int ls_b_hits = 0;
    int fs_b_q[$];
    bit idle_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One pixel clock-enable lasting exactly one clk_sys cycle.
    task automatic step();
        ce = 1'b1;
        @(negedge clk_sys);
        cnt_a++;
        cnt_b++;
        if (a_ls) ls_a_hits++;
        if (b_ls) ls_b_hits++;
        if (b_fs) fs_b_q.push_back(cnt_b);
    endtask

    task automatic step8();
        step();
        ce = 1'b0;
        repeat (7) begin
            @(negedge clk_sys);
            if (a_ls || a_fs) idle_bad = 1'b1;
        end
    endtask

    task automatic reset_a(input logic signed [4:0] ho);
        ce    = 1'b0;
        hoffs = ho;
        rst_a = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst_a     = 1'b0;
        cnt_a     = 0;
        ls_a_hits = 0;
    endtask

    line_vec_t lv[10];
    sync_vec_t sv[9];
    vert_vec_t vv[14];

    initial begin
        lv[0] = '{24,  1'b0, 1'b1, 1'b0, 12'h000, 9'h001};
        lv[1] = '{25,  1'b0, 1'b0, 1'b1, 12'h000, 9'h002};
        lv[2] = '{26,  1'b0, 1'b0, 1'b1, 12'hABC, 9'h003};
        lv[3] = '{264, 1'b0, 1'b0, 1'b1, 12'hABC, 9'd241};
        lv[4] = '{265, 1'b0, 1'b1, 1'b0, 12'hABC, 9'd242};
        lv[5] = '{266, 1'b0, 1'b1, 1'b0, 12'h000, 9'd243};
        lv[6] = '{319, 1'b0, 1'b1, 1'b0, 12'h000, 9'd296};
        lv[7] = '{320, 1'b1, 1'b1, 1'b0, 12'h000, 9'd297};
        lv[8] = '{350, 1'b1, 1'b1, 1'b0, 12'h000, 9'd327};
        lv[9] = '{351, 1'b0, 1'b1, 1'b0, 12'h000, 9'd328};

        sv[0] = '{1'b0, -5'sd16, 303, 1'b0};
        sv[1] = '{1'b0, -5'sd16, 304, 1'b1};
        sv[2] = '{1'b0, -5'sd16, 334, 1'b1};
        sv[3] = '{1'b0, -5'sd16, 335, 1'b0};
        sv[4] = '{1'b1, 5'sd15,  394, 1'b0};
        sv[5] = '{1'b1, 5'sd15,  395, 1'b1};
        sv[6] = '{1'b1, 5'sd15,  396, 1'b1};
        sv[7] = '{1'b1, 5'sd15,  425, 1'b1};
        sv[8] = '{1'b1, 5'sd15,  426, 1'b0};

        vv[0]  = '{0, 0,   1'b0, 1'b0, -1};
        vv[1]  = '{0, 100, 1'b0, 1'b0, 3};
        vv[2]  = '{0, 223, 1'b0, 1'b0, -1};
        vv[3]  = '{0, 224, 1'b1, 1'b0, -1};
        vv[4]  = '{0, 225, 1'b1, 1'b0, -1};
        vv[5]  = '{0, 226, 1'b1, 1'b1, -1};
        vv[6]  = '{0, 230, 1'b1, 1'b1, -1};
        vv[7]  = '{0, 231, 1'b1, 1'b0, -1};
        vv[8]  = '{0, 255, 1'b1, 1'b0, -1};
        vv[9]  = '{1, 0,   1'b0, 1'b0, -1};
        vv[10] = '{1, 228, 1'b1, 1'b0, -1};
        vv[11] = '{1, 229, 1'b1, 1'b1, -1};
        vv[12] = '{1, 233, 1'b1, 1'b1, -1};
        vv[13] = '{1, 234, 1'b1, 1'b0, -1};

        ce = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        hoffs = '0; voffs = '0; rgb_in = 12'hABC;
        repeat (2) @(negedge clk_sys);
        rst_b = 1'b0;

        // Default raster, ce every 8 clocks, zero offsets.
        reset_a(5'sd0);
        check("rst_flags", {a_hb, a_vb, a_hs, a_vs, a_de, a_fs, a_ls}, 7'b1100000);
        check("rst_rgb", a_rgb, 12'h000);
        for (int i = 0; i < 10; i++) begin
            while (cnt_a < lv[i].pos + 1) step8();
            check($sformatf("hs@%0d", lv[i].pos), a_hs, lv[i].hs);
            check($sformatf("hb@%0d", lv[i].pos), a_hb, lv[i].hb);
            check($sformatf("de@%0d", lv[i].pos), a_de, lv[i].de);
            check($sformatf("rgb@%0d", lv[i].pos), a_rgb, lv[i].rgb);
            check($sformatf("hpos@%0d", lv[i].pos), a_hpos, lv[i].hpos);
            check($sformatf("vb@%0d", lv[i].pos), a_vb, 1'b0);
        end
        while (cnt_a < 396) step8();
        check("hpos_at_h0", a_hpos, 9'h1E8);
        check("vpos_line1", a_vpos, 9'd1);
        check("ls_count_line0", ls_a_hits, 1);
        check("pulse_idle_ce8", idle_bad, 1'b0);

        // Sync offsets applied via reset, ce continuously high.
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || sv[i].use_c != sv[i-1].use_c || sv[i].ho != sv[i-1].ho)
                reset_a(sv[i].ho);
            while (cnt_a < sv[i].idx + 1) step();
            check($sformatf("hsync_%s_ofs%0d@%0d", sv[i].use_c ? "c" : "a", sv[i].ho, sv[i].idx),
                  sv[i].use_c ? c_hs : a_hs, sv[i].hs);
        end

        // Reset mid-frame at hcnt=200, vcnt=50 for three clocks with ce high.
        reset_a(5'sd0);
        while (cnt_a < 50 * 396 + 200) step();
        check("pre_rst_hpos", a_hpos, 9'd176);
        check("pre_rst_vpos", a_vpos, 9'd50);
        rst_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            check($sformatf("in_rst_flags%0d", k), {a_hb, a_vb, a_hs, a_vs, a_de, a_fs, a_ls}, 7'b1100000);
            check($sformatf("in_rst_rgb%0d", k), a_rgb, 12'h000);
            check($sformatf("in_rst_pos%0d", k), {a_hpos, a_vpos}, {9'h1E8, 9'h000});
        end
        rst_a = 1'b0; ce = 1'b0; cnt_a = 0; ls_a_hits = 0; idle_bad = 1'b0;
        repeat (50) begin
            @(negedge clk_sys);
            if (a_ls || a_fs) idle_bad = 1'b1;
        end
        check("ce_low_hpos", a_hpos, 9'h1E8);
        check("ce_low_vpos", a_vpos, 9'h000);
        check("ce_low_pulses", idle_bad, 1'b0);
        step();
        ce = 1'b0;
        check("first_ce_hpos", a_hpos, 9'h1E9);
        check("first_ce_blank", {a_hb, a_vb}, 2'b10);
        check("first_ce_no_ls", ls_a_hits, 0);

        // Short-line raster: reset mid-frame, then two frames with a voffs change.
        voffs = '0;
        rst_b = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst_b = 1'b0; cnt_b = 0;
        while (cnt_b < 50 * 40 + 20) step();
        check("b_pre_rst_pos", {b_hpos, b_vpos}, {9'd18, 9'd50});
        rst_b = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("b_rst_pos", {b_hpos, b_vpos}, {9'h1FE, 9'h000});
        check("b_rst_vb", b_vb, 1'b1);
        rst_b = 1'b0; cnt_b = 0; ls_b_hits = 0; fs_b_q.delete();
        for (int i = 0; i < 14; i++) begin
            while (cnt_b < vv[i].frame * 10240 + vv[i].line * 40 + 1) step();
            check($sformatf("vb_f%0d_l%0d", vv[i].frame, vv[i].line), b_vb, vv[i].vb);
            check($sformatf("vs_f%0d_l%0d", vv[i].frame, vv[i].line), b_vs, vv[i].vs);
            check($sformatf("vpos_f%0d_l%0d", vv[i].frame, vv[i].line), b_vpos, 9'(vv[i].line));
            if (vv[i].voffs_set >= 0) voffs = 4'(vv[i].voffs_set);
        end
        while (cnt_b < 20481) step();
        ce = 1'b0;
        check("fs_count", fs_b_q.size(), 2);
        check("fs_first", (fs_b_q.size() > 0) ? fs_b_q[0] : -1, 10240);
        check("fs_second", (fs_b_q.size() > 1) ? fs_b_q[1] : -1, 20480);
        check("ls_count", ls_b_hits, 512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 396x256 per-core timing block.
- Runs on the system clock with a pixel clock-enable instead of using the pixel clock as a clock.
- Generates H/V counters, blanking, sync, game-side pixel coordinates and blanked RGB, plus frame and line pulses.
- Supports user H/V sync offsets. Offsets are latched only at frame start, so the displayed sync never tears.

Parameters:
- H_TOTAL, 396: pixels per line, including blanking.
- H_ACT_B, 25: first active hcnt.
- H_ACT_E, 265: first blanked hcnt after the active region (exclusive).
- HS_START, 320: nominal hsync start hcnt.
- HS_LEN, 31: hsync width in pixels.
- V_TOTAL, 256: lines per frame.
- V_ACT_E, 224: first blanked line. Active lines are 0..V_ACT_E-1.
- VS_START, 226: nominal vsync start line.
- VS_LEN, 5: vsync width in lines.
- HPOS_OFS, 24: subtracted from hcnt to form hpos.
- CNT_W, 9: counter and coordinate width.
- RGB_W, 12: pixel data width.
- HOFFS_W, 5: signed H offset width.
- VOFFS_W, 4: signed V offset width.

Ports:
- clk_sys  in  1  system clock. The block has one clock, clk_sys.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock-enable; all state advances only when it is 1.
- hoffs  in  HOFFS_W  signed H sync offset.
- voffs  in  VOFFS_W  signed V sync offset.
- rgb_in  in  RGB_W  pixel from the game core.
- hpos  out  CNT_W  hcnt - HPOS_OFS, taken modulo 2^CNT_W.
- vpos  out  CNT_W  vcnt.
- rgb_out  out  RGB_W  registered pixel, forced to 0 while blanked.
- hblank  out  1  horizontal blanking.
- vblank  out  1  vertical blanking.
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.
- de  out  1  ~(hblank|vblank).
- frame_start  out  1  one-clk_sys pulse.
- line_start  out  1  one-clk_sys pulse.

Behaviour:
- Reset: hcnt=0, vcnt=0, hblank=1, vblank=1, hsync=0, vsync=0, de=0, rgb_out=0, frame_start=0, line_start=0. The latched offsets are loaded from hoffs/voffs. Reset overrides ce_pix. Reset mid-line restarts at (0,0) on the next ce.
- Counter stepping, on a ce_pix cycle:
  - If hcnt < H_TOTAL-1: hcnt++.
  - Else: hcnt=0, and vcnt = (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
- Counters never exceed H_TOTAL-1 or V_TOTAL-1.
- hpos and vpos are combinational from the counters, so the game sees the coordinate in the same cycle.
- Registered outputs update on ce_pix and are decoded from the pre-increment counters, giving one ce of latency:
  - hblank = (hcnt < H_ACT_B) | (hcnt >= H_ACT_E).
  - vblank = (vcnt >= V_ACT_E).
  - rgb_out = (hblank_q | vblank_q) ? 0 : rgb_in. This uses the already-registered blank flags, matching the legacy one-pixel pipeline.
- Sync positions:
  - hs_b = (HS_START + hoffs_l) mod H_TOTAL. Sign-extend the offset and correct the result by ±H_TOTAL, with no truncation.
  - hsync asserts when hcnt lies within HS_LEN pixels starting at hs_b, wrapping past H_TOTAL-1 to 0.
  - vsync uses the same rule with VS_START, voffs_l, VS_LEN and V_TOTAL.
- Offset latching: hoffs_l and voffs_l load only on the ce cycle where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1. Changes mid-frame take effect next frame.
- Pulses:
  - line_start = 1 for the single clk_sys cycle following a ce where hcnt wrapped to 0.
  - frame_start = 1 for the single cycle following a ce where both counters wrapped to 0.
  - Both are 0 whenever ce_pix holds the counters, including when ce_pix is held low or continuously high.
- ce_pix continuously high is legal and must be handled at full clk_sys rate.
- Elaboration checks, each failing elaboration if violated:
  - H_ACT_B < H_ACT_E <= H_TOTAL.
  - HS_LEN < H_TOTAL.
  - VS_LEN < V_TOTAL.
  - H_TOTAL <= 2^CNT_W.
  - V_TOTAL <= 2^CNT_W.

Decomposition:
- Package video_timing_pkg:
  - Default timing constants for the 396x256 6.144 MHz raster.
  - The wrap-window compare function in_window(cnt, start, len, total).
  - The modular add function wrap_add(base, signed off, total).
- One sub-module, sync_window: counter, start, len, total in; registered flag out. It is instantiated for H and for V.

Test Plan:
- Defaults, ce every 8 clk_sys, zero offsets:
  - hsync high for hcnt 320..350; hblank for hcnt<25 or >=265; vblank for lines 224..255; vsync on lines 226..230.
  - Frame period = 396*256 ce.
- hoffs=-16 → hsync spans 304..334.
- hoffs=+15 with HS_START=380 → hsync spans 395, 0..29, wrapping correctly.
- voffs changed from 0 to 3 at line 100 → the current frame keeps vsync at 226. The next frame shows vsync at 229..233.
- rgb_in=12'hABC constant:
  - rgb_out=0 during blanking.
  - rgb_out=ABC from the ce after hcnt=25 until the ce after hcnt=264.
  - hpos=1 when hcnt=25; hpos=9'h1E8 when hcnt=0.
- Reset asserted at hcnt=200, vcnt=50 for 3 clocks:
  - Outputs take reset values during reset.
  - Counters restart at 0,0.
  - frame_start pulses once after a full frame.
  - ce_pix held low → no counter or pulse activity.
